sw_scan_ctrl: RTL and testbench

- Full-search scan sequencer for the reference-pixel delay-line chain of the motion estimation array.
- Walks the search window in raster order and issues one read address per cycle to the search-window memory (fixed 1-cycle read latency).
- Drives the delay-line shift enable in step with the returning data.
- Flags the cycles where the chain holds a complete candidate block, so the SAD accumulators can latch, and reports the candidate's displacement.

---
 rtl/sw_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_sw_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_scan_ctrl.sv
// Full-search scan sequencer: raster-walks the search window, issues reads and flags complete
// candidate blocks in the delay-line chain. Optional abort port under SW_SCAN_ABORT_EN.
module sw_scan_ctrl #(
    parameter int unsigned BLK = 16,
    parameter int unsigned NX  = 16,
    parameter int unsigned NY  = 16,
    parameter int unsigned AW  = 10,
    localparam int unsigned W  = BLK + NX - 1,
    localparam int unsigned H  = BLK + NY - 1,
    localparam int unsigned CW = $clog2(W),
    localparam int unsigned RW = $clog2(H),
    localparam int unsigned XW = (NX > 1) ? $clog2(NX) : 1,
    localparam int unsigned YW = (NY > 1) ? $clog2(NY) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef SW_SCAN_ABORT_EN
    input  logic          abort,
`endif
    input  logic          start,
    input  logic          hold,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          sr_en,
    output logic          cand_valid,
    output logic [XW-1:0] cand_x,
    output logic [YW-1:0] cand_y,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [CW-1:0] ColLast = CW'(W - 1);
    localparam logic [RW-1:0] RowLast = RW'(H - 1);
    localparam logic [CW-1:0] ColOff  = CW'(BLK - 1);
    localparam logic [RW-1:0] RowOff  = RW'(BLK - 1);

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          sr_en_q, sr_en_d;
    logic          cand_valid_q, cand_valid_d;
    logic [XW-1:0] cand_x_q, cand_x_d;
    logic [YW-1:0] cand_y_q, cand_y_d;

    logic abort_w;
    logic active;
    logic flush;
    logic hit;

`ifdef SW_SCAN_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign active = (state_q == StRun) || (state_q == StDrain);
    assign flush  = abort_w && active;
    assign rd_en  = (state_q == StRun) && !hold;
    assign hit    = rd_en && (row_q >= RowOff) && (col_q >= ColOff);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StRun: begin
                if (rd_en) begin
                    if (col_q == ColLast) begin
                        // Final read leaves the counters parked at the last pixel.
                        if (row_q == RowLast) begin
                            state_d = StDrain;
                        end else begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDrain: state_d = StDone;
            default: begin
                state_d = StIdle;
                row_d   = '0;
                col_d   = '0;
            end
        endcase
        if (flush) begin
            state_d = StIdle;
            row_d   = '0;
            col_d   = '0;
        end
    end

    // Pipe stage mirrors the memory's one-cycle read latency.
    always_comb begin
        sr_en_d      = rd_en && !flush;
        cand_valid_d = hit && !flush;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        if (hit && !flush) begin
            cand_x_d = XW'(col_q - ColOff);
            cand_y_d = YW'(row_q - RowOff);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            sr_en_q      <= 1'b0;
            cand_valid_q <= 1'b0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            sr_en_q      <= sr_en_d;
            cand_valid_q <= cand_valid_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
        end
    end

    assign rd_addr    = (state_q == StRun) ? (AW'(row_q) * AW'(W) + AW'(col_q)) : '0;
    assign sr_en      = sr_en_q;
    assign cand_valid = cand_valid_q;
    assign cand_x     = cand_x_q;
    assign cand_y     = cand_y_q;
    assign busy       = active;
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_sw_scan_ctrl.sv
// Scoreboard bench for sw_scan_ctrl (BLK=2, NX=NY=3); abort scenario under SW_SCAN_ABORT_EN.
module tb_sw_scan_ctrl;

    localparam int BLK = 2;
    localparam int NX  = 3;
    localparam int NY  = 3;
    localparam int AW  = 4;
    localparam int W   = BLK + NX - 1;
    localparam int H   = BLK + NY - 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          hold;
    logic          abort;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          sr_en;
    logic          cand_valid;
    logic [1:0]    cand_x;
    logic [1:0]    cand_y;
    logic          busy;
    logic          done;

    sw_scan_ctrl #(
        .BLK(BLK),
        .NX (NX),
        .NY (NY),
        .AW (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SW_SCAN_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .hold      (hold),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .sr_en     (sr_en),
        .cand_valid(cand_valid),
        .cand_x    (cand_x),
        .cand_y    (cand_y),
        .busy      (busy),
        .done      (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int exp_addr[$];
    int exp_cx[$];
    int exp_cy[$];
    int exp_done[$];

    int prev_rd    = 0;
    int prev_abort = 0;
    int prev_a     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_sr_en"}, int'(sr_en), 0);
        chk({tag, "_cand_valid"}, int'(cand_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    task automatic clear_exp();
        exp_addr.delete();
        exp_cx.delete();
        exp_cy.delete();
        exp_done.delete();
    endtask

    // Monitor: pops expectations whenever the DUT presents a read, a candidate or done.
    initial begin
        int e;
        int exp_sr;
        int exp_cv;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rd    = 0;
                prev_abort = 0;
            end else begin
                exp_sr = (prev_rd != 0 && prev_abort == 0) ? 1 : 0;
                chk("sr_en", int'(sr_en), exp_sr);
                exp_cv = (exp_sr != 0 && (prev_a / W) >= BLK - 1 &&
                          (prev_a % W) >= BLK - 1) ? 1 : 0;
                chk("cand_valid", int'(cand_valid), exp_cv);
                if (cand_valid) begin
                    if (exp_cx.size() == 0) begin
                        chk("cand_unexpected", int'(cand_valid), 0);
                    end else begin
                        chk("cand_x", int'(cand_x), exp_cx.pop_front());
                        chk("cand_y", int'(cand_y), exp_cy.pop_front());
                    end
                end
                if (rd_en) begin
                    chk("busy_in_run", int'(busy), 1);
                    if (exp_addr.size() == 0) begin
                        chk("rd_unexpected", int'(rd_en), 0);
                    end else begin
                        e = exp_addr.pop_front();
                        chk("rd_addr", int'(rd_addr), e);
                        prev_a = e;
                    end
                end
                if (done) begin
                    chk("busy_at_done", int'(busy), 0);
                    if (exp_done.size() == 0) begin
                        chk("done_unexpected", int'(done), 0);
                    end else begin
                        chk("done_cycle", cyc, exp_done.pop_front());
                    end
                end
                prev_rd    = rd_en ? 1 : 0;
                prev_abort = abort ? 1 : 0;
            end
        end
    end

    // Driver; entered and left at posedge+1 of an IDLE cycle.
    // hmode: 0 no hold, 1 scripted holds, 2 random holds. cut_at >= 0 interrupts the scan
    // when read number cut_at is about to issue (reset, or abort when cut_abort).
    task automatic run_scan(input int hmode, input bit keep_start, input int cut_at,
                            input bit cut_abort);
        int c0;
        int reads;
        int stalls;
        int h5;
        int hl;
        bit hb;
        for (int a = 0; a < W * H; a++) exp_addr.push_back(a);
        for (int y = 0; y < NY; y++) begin
            for (int x = 0; x < NX; x++) begin
                exp_cx.push_back(x);
                exp_cy.push_back(y);
            end
        end
        c0     = cyc;
        start  = 1'b1;
        reads  = 0;
        stalls = 0;
        h5     = 0;
        hl     = 0;
        while (reads < W * H) begin
            @(posedge clk);
            #1;
            if (!keep_start) start = 1'b0;
            if (cut_at >= 0 && reads == cut_at) begin
                hold = 1'b0;
                if (cut_abort) begin
                    abort = 1'b1;
                    @(posedge clk);
                    #1;
                    abort = 1'b0;
                    clear_exp();
                    chk_quiet("after_abort");
                end else begin
                    #1;
                    rst_n = 1'b0;
                    #1;
                    clear_exp();
                    chk_quiet("in_reset");
                    chk("in_reset_cand_x", int'(cand_x), 0);
                    chk("in_reset_cand_y", int'(cand_y), 0);
                    @(negedge clk);
                    #2;
                    rst_n = 1'b1;
                    @(posedge clk);
                    #1;
                    chk_quiet("after_reset");
                end
                return;
            end
            hb = 1'b0;
            if (hmode == 1) begin
                if (reads == 5 && h5 < 3) begin
                    hb = 1'b1;
                    h5++;
                end else if (reads == W * H - 1 && hl < 1) begin
                    hb = 1'b1;
                    hl++;
                end
            end else if (hmode == 2) begin
                hb = ($urandom_range(0, 3) == 0);
            end
            hold = hb;
            if (hb) stalls++;
            else reads++;
        end
        // Last read at c0+16+stalls, then DRAIN, then DONE.
        exp_done.push_back(c0 + W * H + 2 + stalls);
        repeat (2) begin
            @(posedge clk);
            #1;
            hold = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
        chk("idle_after_done", int'(busy), 0);
        chk("done_seen", exp_done.size(), 0);
        chk("reads_consumed", exp_addr.size(), 0);
        chk("cands_consumed", exp_cx.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        #3;
        chk_quiet("reset");
        chk("reset_cand_x", int'(cand_x), 0);
        chk("reset_cand_y", int'(cand_y), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_quiet("idle");

        run_scan(0, 1'b0, -1, 1'b0);
        run_scan(1, 1'b0, -1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        run_scan(2, 1'b1, -1, 1'b0);
        run_scan(0, 1'b1, -1, 1'b0);
        start = 1'b0;
        run_scan(0, 1'b0, 7, 1'b0);
        run_scan(0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_scan(2, 1'b0, -1, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
`ifdef SW_SCAN_ABORT_EN
        run_scan(0, 1'b0, 10, 1'b1);
        run_scan(2, 1'b0, -1, 1'b0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("final_idle");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
